reg_scoreboard: RTL and testbench

- Write-side counterpart of the 5-bit register-address selection path: takes the destination address chosen for each instruction and tracks pending writes per architectural register.
- Decodes each retiring write into a one-hot register-file write enable.
- Reports busy status for the rs/rt source operands, so the hazard unit can stall.
- Sits between decode (issue) and writeback (retire) in the MIPS pipeline.

---
 rtl/reg_scoreboard.sv | 89 ++++++++
 tb/tb_reg_scoreboard.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write scoreboard with one-hot write enable
//
// Tracks how many writes are in flight for each architectural register.
// Issue increments and retire decrements a small saturating counter per register.
// Register 0 is hard-wired to idle.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   issue_valid, issue_rd    destination of the issuing instruction
//   issue_ready              0 when the destination counter is full (stall)
//   retire_valid, retire_rd  destination of the retiring write
//   rs_addr, rt_addr         source operand addresses
//   rs_busy, rt_busy         source operand has a pending write
//   we_onehot                one-hot register-file write enable for the retire
//   busy_vec                 per-register pending-write flags
//   underflow_err            sticky: retire seen for a register with nothing pending
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            retire_valid,
    input  logic [AW-1:0]   retire_rd,
    input  logic [AW-1:0]   rs_addr,
    input  logic [AW-1:0]   rt_addr,
    output logic            rs_busy,
    output logic            rt_busy,
    output logic [NREG-1:0] we_onehot,
    output logic [NREG-1:0] busy_vec,
    output logic            underflow_err
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0]   cnt [NREG];
    logic            acc;
    logic            ret;
    logic [NREG-1:0] inc_vec;

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_vec[i] = (cnt[i] != '0);
        end
    end

    assign rs_busy = busy_vec[rs_addr];
    assign rt_busy = busy_vec[rt_addr];

    // The issue_valid input is deliberately excluded from this check, so the
    // hazard unit sees a stable ready signal for the address it presents.
    assign issue_ready = !((issue_rd != '0) && (cnt[issue_rd] == CNT_MAX));

    assign acc = issue_valid && issue_ready && (issue_rd != '0);
    assign ret = retire_valid && (retire_rd != '0);

    assign inc_vec   = acc ? (NREG'(1) << issue_rd)  : '0;
    assign we_onehot = ret ? (NREG'(1) << retire_rd) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            underflow_err <= 1'b0;
        end else begin
            // cnt[0] is never written here, so it stays at its reset value of 0.
            for (int i = 1; i < NREG; i++) begin
                if (inc_vec[i] && !we_onehot[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (!inc_vec[i] && we_onehot[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end else if (inc_vec[i] && we_onehot[i] && (cnt[i] == '0)) begin
                    // The retire is an underflow and is dropped; the issue still counts.
                    cnt[i] <= CW'(1);
                end
            end
            if (ret && (cnt[retire_rd] == '0)) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_busy;
    logic        rt_busy;
    logic [31:0] we_onehot;
    logic [31:0] busy_vec;
    logic        underflow_err;

    int passed = 0;
    int total  = 0;

    reg_scoreboard #(.NREG(32), .AW(5), .CW(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .retire_valid  (retire_valid),
        .retire_rd     (retire_rd),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_busy       (rs_busy),
        .rt_busy       (rt_busy),
        .we_onehot     (we_onehot),
        .busy_vec      (busy_vec),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        retire_valid = 1'b0; retire_rd = '0;
        rs_addr = 5'd8; rt_addr = 5'd9;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_busy_vec", busy_vec, 32'h0);
        chk("reset_rs_busy", 32'(rs_busy), 32'h0);
        chk("reset_rt_busy", 32'(rt_busy), 32'h0);
        chk("reset_issue_ready", 32'(issue_ready), 32'h1);
        chk("reset_underflow", 32'(underflow_err), 32'h0);

        // single issue / retire of r8
        issue_valid = 1'b1; issue_rd = 5'd8;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("r8_busy_vec", busy_vec, 32'h0000_0100);
        chk("r8_rs_busy", 32'(rs_busy), 32'h1);
        chk("r8_rt_busy", 32'(rt_busy), 32'h0);
        retire_valid = 1'b1; retire_rd = 5'd8;
        #1;
        chk("r8_we_onehot", we_onehot, 32'h0000_0100);
        tick();
        retire_valid = 1'b0;
        #1;
        chk("r8_cleared", busy_vec, 32'h0);
        chk("r8_we_idle", we_onehot, 32'h0);

        // saturate r5
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        chk("r5_ready_empty", 32'(issue_ready), 32'h1);
        tick(); tick(); tick();
        chk("r5_full_stall", 32'(issue_ready), 32'h0);
        chk("r5_full_busy", busy_vec, 32'h0000_0020);
        retire_valid = 1'b1; retire_rd = 5'd5;
        #1;
        chk("r5_stall_with_retire", 32'(issue_ready), 32'h0);
        chk("r5_we_onehot", we_onehot, 32'h0000_0020);
        tick();
        retire_valid = 1'b0;
        #1;
        chk("r5_released", 32'(issue_ready), 32'h1);
        tick();
        chk("r5_refilled", 32'(issue_ready), 32'h0);
        issue_valid = 1'b0;
        retire_valid = 1'b1; retire_rd = 5'd5;
        tick(); tick();
        chk("r5_one_left", busy_vec, 32'h0000_0020);
        tick();
        retire_valid = 1'b0;
        #1;
        chk("r5_drained", busy_vec, 32'h0);
        chk("r5_no_underflow", 32'(underflow_err), 32'h0);

        // same-cycle issue and retire on r12 with cnt=1
        issue_valid = 1'b1; issue_rd = 5'd12;
        tick();
        retire_valid = 1'b1; retire_rd = 5'd12;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("r12_net_zero", busy_vec, 32'h0000_1000);
        tick();
        retire_valid = 1'b0;
        #1;
        chk("r12_cleared", busy_vec, 32'h0);
        chk("r12_no_underflow", 32'(underflow_err), 32'h0);

        // underflow on r3
        retire_valid = 1'b1; retire_rd = 5'd3;
        tick();
        retire_valid = 1'b0;
        #1;
        chk("r3_underflow", 32'(underflow_err), 32'h1);
        chk("r3_not_busy", busy_vec, 32'h0);
        tick();
        chk("r3_underflow_sticky", 32'(underflow_err), 32'h1);

        // register 0 is ignored
        issue_valid = 1'b1; issue_rd = 5'd0;
        retire_valid = 1'b1; retire_rd = 5'd0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        chk("r0_ready", 32'(issue_ready), 32'h1);
        chk("r0_we_onehot", we_onehot, 32'h0);
        tick();
        issue_valid = 1'b0; retire_valid = 1'b0;
        #1;
        chk("r0_busy_vec", busy_vec, 32'h0);
        chk("r0_rs_busy", 32'(rs_busy), 32'h0);
        chk("r0_underflow_kept", 32'(underflow_err), 32'h1);

        // same-cycle issue and retire on an idle register r10
        issue_valid = 1'b1; issue_rd = 5'd10;
        retire_valid = 1'b1; retire_rd = 5'd10;
        tick();
        issue_valid = 1'b0; retire_valid = 1'b0;
        #1;
        chk("r10_counted", busy_vec, 32'h0000_0400);
        retire_valid = 1'b1; retire_rd = 5'd10;
        tick();
        retire_valid = 1'b0;
        #1;
        chk("r10_cleared", busy_vec, 32'h0);

        // asynchronous reset with cnt[7]=2
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick(); tick();
        chk("r7_busy_before_rst", busy_vec, 32'h0000_0080);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy_vec, 32'h0);
        chk("async_rst_underflow", 32'(underflow_err), 32'h0);
        chk("async_rst_ready", 32'(issue_ready), 32'h1);
        tick();
        chk("rst_discards_issue", busy_vec, 32'h0);
        rst = 1'b0;
        rs_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        #1;
        chk("post_rst_tracked", busy_vec, 32'h0000_0080);
        chk("post_rst_rs_busy", 32'(rs_busy), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
